conv_window_ctrl: RTL and testbench

Write-side and read-side controller for the convolution front end. It accepts a raster pixel stream and distributes it round-robin across four internal line stores. Once three complete lines are buffered, it drives the read strobes and assembles a registered 3x3 window for the convolution datapath. It pulses an interrupt each time a line has been fully consumed, so the upstream DMA can refill it.

---
 rtl/conv_pkg.sv | 13 +
 rtl/line_store.sv | 34 +++
 rtl/conv_window_ctrl.sv | 107 ++++++++++
 tb/tb_conv_window_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window front end.
package conv_pkg;
  localparam int NUM_LINES = 4;

  function automatic int pix_w(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } rd_state_e;
endpackage

// File: rtl/line_store.sv
// One line buffer: sequential write port, 3-pixel sliding read port.
module line_store import conv_pkg::*; #(
  parameter int W     = 13,
  parameter int DEPTH = 512
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [W-1:0]   i_wr_data,
  input  logic           i_wr_valid,
  input  logic           i_rd_strobe,
  output logic [3*W-1:0] o_rd_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_wr_valid)  wr_ptr <= wr_ptr + 1'b1;
      if (i_rd_strobe) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_valid) mem[wr_ptr] <= i_wr_data;
  end

  // Pointer arithmetic wraps at DEPTH, so the tail of a line sees columns 0 and 1.
  assign o_rd_data = {mem[rd_ptr], mem[rd_ptr + AW'(1)], mem[rd_ptr + AW'(2)]};
endmodule

// File: rtl/conv_window_ctrl.sv
// Round-robin line buffering and 3x3 window assembly for the conv front end.
// Define CONV_WINDOW_WRAP_EN to also flag the two wrapped windows at line end as valid.
module conv_window_ctrl import conv_pkg::*; #(
  parameter  int INTEGER_BITS     = 9,
  parameter  int FIXED_POINT_BITS = 4,
  parameter  int LINE_WIDTH       = 512,
  localparam int W                = pix_w(INTEGER_BITS, FIXED_POINT_BITS)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [W-1:0]   i_pixel_data,
  input  logic           i_pixel_data_valid,
  output logic [9*W-1:0] o_window,
  output logic           o_window_valid,
  output logic           o_intr,
  output logic           o_full
);
  localparam int             CW       = $clog2(LINE_WIDTH);
  localparam int             TW       = $clog2(NUM_LINES*LINE_WIDTH) + 1;
  localparam logic [TW-1:0]  CAP      = TW'(NUM_LINES*LINE_WIDTH);
  localparam logic [TW-1:0]  RD_THR   = TW'(3*LINE_WIDTH);
  localparam logic [CW-1:0]  LAST_COL = CW'(LINE_WIDTH-1);
  localparam logic [CW-1:0]  LAST_VLD = CW'(LINE_WIDTH-3);

  logic [CW-1:0] wr_col, rd_col;
  logic [1:0]    wr_sel, rd_sel;
  logic [TW-1:0] total_cnt;
  rd_state_e     state, state_nxt;
  logic          accept, strobe, last_col, win_ok;

  logic [NUM_LINES-1:0]          st_wr, st_rd;
  logic [NUM_LINES-1:0][3*W-1:0] st_data;

  assign o_full = (total_cnt == CAP);
  assign accept = i_pixel_data_valid && !o_full;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    localparam logic [1:0] IDX = 2'(g);
    assign st_wr[g] = accept && (wr_sel == IDX);
    // Read the three stores rd_sel..rd_sel+2; the remaining one is the write target.
    assign st_rd[g] = strobe && ((IDX - rd_sel) != 2'd3);
    line_store #(.W(W), .DEPTH(LINE_WIDTH)) u_line (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr_data   (i_pixel_data),
      .i_wr_valid  (st_wr[g]),
      .i_rd_strobe (st_rd[g]),
      .o_rd_data   (st_data[g])
    );
  end

`ifdef CONV_WINDOW_WRAP_EN
  assign win_ok = 1'b1;
`else
  assign win_ok = (rd_col <= LAST_VLD);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (total_cnt >= RD_THR) state_nxt = RD;
      RD:      if (rd_col == LAST_COL)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    strobe   = 1'b0;
    last_col = 1'b0;
    if (state == RD) begin
      strobe   = 1'b1;
      last_col = (rd_col == LAST_COL);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_col         <= '0;
      wr_sel         <= '0;
      rd_col         <= '0;
      rd_sel         <= '0;
      total_cnt      <= '0;
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_intr         <= 1'b0;
    end else begin
      if (accept) begin
        wr_col <= wr_col + 1'b1;
        if (wr_col == LAST_COL) wr_sel <= wr_sel + 1'b1;
      end
      if (accept && !strobe)      total_cnt <= total_cnt + 1'b1;
      else if (!accept && strobe) total_cnt <= total_cnt - 1'b1;
      if (strobe) begin
        rd_col   <= rd_col + 1'b1;
        o_window <= {st_data[rd_sel], st_data[rd_sel + 2'd1], st_data[rd_sel + 2'd2]};
        if (last_col) rd_sel <= rd_sel + 1'b1;
      end
      o_window_valid <= strobe && win_ok;
      o_intr         <= last_col;
    end
  end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench: a 512-wide instance for fill/stream/reset and a 4-wide one for the full case.
module tb_conv_window_ctrl;
  localparam int IB = 9, FB = 4, W = IB + FB, LW = 512, LWS = 4;
`ifdef CONV_WINDOW_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    int             cyc;
    logic [9*W-1:0] w;
  } obs_t;

  logic clk;
  logic rst, rst_s, pv, pv_s;
  logic [W-1:0] pd, pd_s;
  logic [9*W-1:0] win, win_s;
  logic wv, wv_s, intr, intr_s, full, full_s;

  int   total = 0, bad = 0;
  obs_t wq[$];
  int   iq[$];
  int   full_first, n_full;

  conv_window_ctrl #(.INTEGER_BITS(IB), .FIXED_POINT_BITS(FB), .LINE_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst(rst), .i_pixel_data(pd), .i_pixel_data_valid(pv),
    .o_window(win), .o_window_valid(wv), .o_intr(intr), .o_full(full));

  conv_window_ctrl #(.INTEGER_BITS(IB), .FIXED_POINT_BITS(FB), .LINE_WIDTH(LWS)) dut_s (
    .i_clk(clk), .i_rst(rst_s), .i_pixel_data(pd_s), .i_pixel_data_valid(pv_s),
    .o_window(win_s), .o_window_valid(wv_s), .o_intr(intr_s), .o_full(full_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line k column c of the plain fill holds k*LW+c.
  function automatic logic [9*W-1:0] big_win(input int k, input int col);
    logic [9*W-1:0] r;
    r = '0;
    for (int row = 0; row < 3; row++)
      for (int t = 0; t < 3; t++)
        r = {r[8*W-1:0], W'((k + row) * LW + (col + t) % LW)};
    return r;
  endfunction

  // Accepted stream of the small instance: offered value 28 is dropped, so line 7 starts at 29.
  function automatic int sval(input int line, input int c);
    return (line < 7) ? 4 * line + c : 29 + c;
  endfunction

  function automatic logic [9*W-1:0] small_win(input int k, input int col);
    logic [9*W-1:0] r;
    r = '0;
    for (int row = 0; row < 3; row++)
      for (int t = 0; t < 3; t++)
        r = {r[8*W-1:0], W'(sval(k + row, (col + t) % LWS))};
    return r;
  endfunction

  // Cycle i presents pixel i (for i < nwr); outputs observed after the edge belong to cycle i+1.
  task automatic run(input bit sel, input int ncyc, input int nwr);
    logic [9*W-1:0] ow;
    logic ovld, ointr, ofull;
    wq.delete();
    iq.delete();
    full_first = -1;
    n_full     = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (sel) begin pv_s = (i < nwr); pd_s = W'(i); end
      else     begin pv   = (i < nwr); pd   = W'(i); end
      @(posedge clk); #1;
      ow    = sel ? win_s  : win;
      ovld  = sel ? wv_s   : wv;
      ointr = sel ? intr_s : intr;
      ofull = sel ? full_s : full;
      if (ovld)  wq.push_back('{i + 1, ow});
      if (ointr) iq.push_back(i + 1);
      if (ofull) begin
        n_full++;
        if (full_first < 0) full_first = i + 1;
      end
    end
    pv   = 1'b0;
    pv_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_s = 1'b1; pv = 1'b0; pv_s = 1'b0; pd = '0; pd_s = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (win !== '0 || wv !== 1'b0 || intr !== 1'b0 || full !== 1'b0) begin
      bad++;
      $display("FAIL reset_big: win=%h vld=%b intr=%b full=%b, want all 0", win, wv, intr, full);
    end
    total++;
    if (win_s !== '0 || wv_s !== 1'b0 || intr_s !== 1'b0 || full_s !== 1'b0) begin
      bad++;
      $display("FAIL reset_small: win=%h vld=%b intr=%b full=%b, want all 0", win_s, wv_s, intr_s, full_s);
    end
    rst = 1'b0; rst_s = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      total++;
      if ({wv, intr, full, wv_s, intr_s, full_s} !== 6'b0 || win !== '0) begin
        bad++;
        $display("FAIL idle_quiet cyc=%0d: vld=%b intr=%b full=%b win=%h, want 0", i, wv, intr, full, win);
      end
    end
  endtask

  // Four lines back to back: the fourth lands while the first pass is reading.
  task automatic test_fill();
    int npl, exp_cyc;
    npl = WRAP ? LW : LW - 2;
    run(1'b0, 2700, 2048);
    total++;
    if (wq.size() != 2 * npl) begin
      bad++; $display("FAIL fill_count: got %0d windows, want %0d", wq.size(), 2 * npl);
    end
    total++;
    if (wq.size() == 0 || wq[0].cyc != 1538) begin
      bad++; $display("FAIL fill_latency: first valid at cycle %0d, want 1538", wq.size() ? wq[0].cyc : -1);
    end
    for (int j = 0; j < 2 * npl; j++) begin
      exp_cyc = (j < npl ? 1538 : 2051) + j % npl;
      total++;
      if (j >= wq.size() || wq[j].w !== big_win(j / npl, j % npl) || wq[j].cyc != exp_cyc) begin
        bad++;
        $display("FAIL fill_win[%0d]: got %h @%0d, want %h @%0d", j,
                 j < wq.size() ? wq[j].w : '0, j < wq.size() ? wq[j].cyc : -1,
                 big_win(j / npl, j % npl), exp_cyc);
      end
    end
    total++;
    if (iq.size() != 2 || iq[0] != 2049 || iq[1] != 2562) begin
      bad++;
      $display("FAIL fill_intr: %0d pulses first=%0d second=%0d, want 2 at 2049,2562",
               iq.size(), iq.size() > 0 ? iq[0] : -1, iq.size() > 1 ? iq[1] : -1);
    end
    total++;
    if (full_first != -1) begin
      bad++; $display("FAIL fill_nofull: full seen at cycle %0d, want never", full_first);
    end
  endtask

  task automatic test_reset_mid_rd();
    int npl;
    npl = WRAP ? LW : LW - 2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(1'b0, 1637, 1536);
    total++;
    if (wv !== 1'b1 || win !== big_win(0, 99)) begin
      bad++; $display("FAIL midrd_pre: vld=%b win=%h, want 1 %h", wv, win, big_win(0, 99));
    end
    rst = 1'b1;
    #1;
    total++;
    if (wv !== 1'b0 || win !== '0 || intr !== 1'b0 || full !== 1'b0) begin
      bad++; $display("FAIL midrd_async: vld=%b win=%h intr=%b full=%b, want all 0", wv, win, intr, full);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(1'b0, 2100, 1536);
    total++;
    if (wq.size() != npl) begin
      bad++; $display("FAIL refill_count: got %0d windows, want %0d", wq.size(), npl);
    end
    total++;
    if (wq.size() == 0 || wq[0].cyc != 1538 || wq[0].w !== big_win(0, 0)) begin
      bad++; $display("FAIL refill_first: got %h @%0d, want %h @1538",
                      wq.size() ? wq[0].w : '0, wq.size() ? wq[0].cyc : -1, big_win(0, 0));
    end
    total++;
    if (wq.size() == 0 || wq[wq.size()-1].w !== big_win(0, npl - 1)) begin
      bad++; $display("FAIL refill_last: got %h, want %h",
                      wq.size() ? wq[wq.size()-1].w : '0, big_win(0, npl - 1));
    end
    total++;
    if (iq.size() != 1 || iq[0] != 2049) begin
      bad++; $display("FAIL refill_intr: %0d pulses first=%0d, want 1 at 2049", iq.size(), iq.size() ? iq[0] : -1);
    end
  endtask

  // Small instance streamed until full; one pixel is dropped and must be missing from line 7.
  task automatic test_full();
    int nps, idx;
    nps = WRAP ? LWS : LWS - 2;
    run(1'b1, 60, 33);
    total++;
    if (full_first != 28 || n_full != 2) begin
      bad++; $display("FAIL full_flag: first=%0d cycles=%0d, want 28 and 2", full_first, n_full);
    end
    total++;
    if (iq.size() != 6 || iq[0] != 17 || iq[5] != 42) begin
      bad++; $display("FAIL full_intr: %0d pulses first=%0d last=%0d, want 6 at 17..42",
                      iq.size(), iq.size() ? iq[0] : -1, iq.size() ? iq[iq.size()-1] : -1);
    end
    total++;
    if (wq.size() != 6 * nps) begin
      bad++; $display("FAIL full_count: got %0d windows, want %0d", wq.size(), 6 * nps);
    end
    total++;
    if (wq.size() == 0 || wq[0].cyc != 14 || wq[0].w !== small_win(0, 0)) begin
      bad++; $display("FAIL full_first: got %h @%0d, want %h @14",
                      wq.size() ? wq[0].w : '0, wq.size() ? wq[0].cyc : -1, small_win(0, 0));
    end
    for (int p = 4; p < 6; p++) begin
      for (int j = 0; j < nps; j++) begin
        idx = p * nps + j;
        total++;
        if (idx >= wq.size() || wq[idx].w !== small_win(p, j) || wq[idx].cyc != (p == 4 ? 34 : 39) + j) begin
          bad++;
          $display("FAIL full_pass%0d[%0d]: got %h @%0d, want %h @%0d", p + 1, j,
                   idx < wq.size() ? wq[idx].w : '0, idx < wq.size() ? wq[idx].cyc : -1,
                   small_win(p, j), (p == 4 ? 34 : 39) + j);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_reset_mid_rd();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
